alu_operand_stage: RTL

Registered successor to the combinational ALU operand selector: it decodes opcode/func, resolves data hazards by forwarding from up to `NUM_FWD` later pipeline stages, forms the two ALU operands, and holds them in a valid/ready pipeline register feeding the EX stage. It sits between register-file read (ID) and the ALU. It is generalised in data width and forwarding-source count, and adds `ori`/`lui` immediate handling, flush, and back-pressure.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/fwd_mux.sv | 36 +++
 rtl/alu_operand_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/func encodings and operand-class decode for the
// ALU operand stage.
//   OP_* / FN_*    : MIPS opcode and R-type func field values
//   opnd_class_e   : how the two ALU operands are formed for an instruction
//   classify()     : pure decode of {opcode, func} into opnd_class_e
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  typedef enum logic [2:0] {
    OC_RR   = 3'd0,  // A, B
    OC_SHV  = 3'd1,  // B, A[SHW-1:0]
    OC_SHI  = 3'd2,  // B, shamt
    OC_BR   = 3'd3,  // A, B
    OC_ZIMM = 3'd4,  // A, zero-extended imm
    OC_LUI  = 3'd5,  // 0, imm << 16
    OC_SIMM = 3'd6   // A, sign-extended imm
  } opnd_class_e;

  function automatic opnd_class_e classify(input logic [5:0] opcode,
                                           input logic [5:0] func);
    opnd_class_e c;
    c = OC_SIMM;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_SLLV, FN_SRLV, FN_SRAV: c = OC_SHV;
          FN_SLL, FN_SRL, FN_SRA:    c = OC_SHI;
          default:                   c = OC_RR;
        endcase
      end
      OP_BEQ, OP_BNE:           c = OC_BR;
      OP_ANDI, OP_ORI, OP_XORI: c = OC_ZIMM;
      OP_LUI:                   c = OC_LUI;
      default:                  c = OC_SIMM;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: resolves one source operand against NUM_FWD forwarding sources.
//   addr_i      : source register number
//   reg_data_i  : register-file read value
//   fwd_valid_i : per-source "will write fwd_addr" flag
//   fwd_addr_i  : packed 5-bit destination numbers, source i at [5*i +: 5]
//   fwd_data_i  : packed results, source i at [XLEN*i +: XLEN]
//   data_o      : resolved operand
//   hit_o       : data_o came from a forwarding source
module fwd_mux #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]              addr_i,
  input  logic [XLEN-1:0]         reg_data_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [5*NUM_FWD-1:0]    fwd_addr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  output logic [XLEN-1:0]         data_o,
  output logic                    hit_o
);

  // Scan from the oldest source down so the lowest matching index is the
  // last assignment and therefore wins. Register 0 is hard-wired zero and
  // never takes a forwarded value.
  always_comb begin
    data_o = reg_data_i;
    hit_o  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (fwd_addr_i[5*i +: 5] == addr_i) && (addr_i != 5'd0)) begin
        data_o = fwd_data_i[XLEN*i +: XLEN];
        hit_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decodes opcode/func, forwards rs/rt from later pipeline
// stages, forms the two ALU operands and holds them in a one-entry
// valid/ready register feeding EX.
//   in_valid/in_ready   : ID-side handshake; transfer when both are high
//   out_valid/out_ready : EX-side handshake; transfer when both are high
//   rs_addr, rt_addr, reg_a, reg_b, shamt, imm, opcode, func : decoded fields
//   fwd_valid/fwd_addr/fwd_data : forwarding sources, index 0 youngest
//   flush               : drop held and incoming instruction
//   out_a, out_b        : ALU operands; out_fwd_a/out_fwd_b : forwarded flags
// Handshake: a producer holding valid keeps its payload stable until the
// cycle ready is seen; in_ready = !out_valid || out_ready, so every output
// is bit-stable while out_valid && !out_ready.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              rs_addr,
  input  logic [4:0]              rt_addr,
  input  logic [XLEN-1:0]         reg_a,
  input  logic [XLEN-1:0]         reg_b,
  input  logic [4:0]              shamt,
  input  logic [15:0]             imm,
  input  logic [5:0]              opcode,
  input  logic [5:0]              func,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_a,
  output logic [XLEN-1:0]         out_b,
  output logic                    out_fwd_a,
  output logic                    out_fwd_b
);

  localparam int SHW = $clog2(XLEN);
  // Keeps the low SHW bits; XLEN > SHW always holds for XLEN >= 16.
  localparam logic [XLEN-1:0] SH_MASK = {{(XLEN-SHW){1'b0}}, {SHW{1'b1}}};

  logic [XLEN-1:0] a_val, b_val;
  logic            a_hit, b_hit;

  fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs (
    .addr_i(rs_addr), .reg_data_i(reg_a), .fwd_valid_i(fwd_valid),
    .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data), .data_o(a_val), .hit_o(a_hit)
  );

  fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rt (
    .addr_i(rt_addr), .reg_data_i(reg_b), .fwd_valid_i(fwd_valid),
    .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data), .data_o(b_val), .hit_o(b_hit)
  );

  // Wide temporaries so the sign/zero fills never need a zero-width replicate.
  // lui_w low XLEN bits: XLEN=32 gives {imm,16'h0}; wider XLEN sign-extends
  // from bit 31 (imm[15]).
  logic [XLEN+15:0] simm_w;
  logic [XLEN+31:0] lui_w;
  assign simm_w = {{XLEN{imm[15]}}, imm};
  assign lui_w  = {{XLEN{imm[15]}}, imm, 16'h0000};

  opnd_class_e     cls;
  logic [XLEN-1:0] a_d, b_d;
  logic            fwd_a_d, fwd_b_d;

  always_comb begin
    cls     = classify(opcode, func);
    a_d     = a_val;
    b_d     = b_val;
    fwd_a_d = a_hit;
    fwd_b_d = b_hit;
    case (cls)
      OC_SHV: begin
        a_d     = b_val;
        b_d     = a_val & SH_MASK;
        fwd_a_d = b_hit;
        fwd_b_d = a_hit;
      end
      OC_SHI: begin
        // Masking handles both zero-extension (SHW>5) and truncation (SHW<5).
        a_d     = b_val;
        b_d     = XLEN'(shamt) & SH_MASK;
        fwd_a_d = b_hit;
        fwd_b_d = 1'b0;
      end
      OC_ZIMM: begin
        b_d     = XLEN'(imm);
        fwd_b_d = 1'b0;
      end
      OC_LUI: begin
        a_d     = '0;
        b_d     = lui_w[XLEN-1:0];
        fwd_a_d = 1'b0;
        fwd_b_d = 1'b0;
      end
      OC_SIMM: begin
        b_d     = simm_w[XLEN-1:0];
        fwd_b_d = 1'b0;
      end
      default: ;  // OC_RR, OC_BR: A, B as resolved
    endcase
  end

  logic            valid_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            fwd_a_q, fwd_b_q;
  logic            load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  // Flush wins over load and drain; data registers are left stale on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fwd_a_q <= 1'b0;
      fwd_b_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_fwd_a = fwd_a_q;
  assign out_fwd_b = fwd_b_q;

endmodule
